// File: rtl/cpfsk_if.sv
// Word handshake between the byte source and the CPFSK modulator.
// The source drives valid/data; the modulator drives ready.
interface cpfsk_if #(
  parameter int WORD_W = 8
);
  logic              s_valid;
  logic              s_ready;
  logic [WORD_W-1:0] s_data;

  modport master (output s_valid, output s_data, input s_ready);
  modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/cpfsk_modulator.sv
// Continuous-phase binary FSK modulator: NCO plus sine ROM, one tone per data bit.
// Phase carries across bits and back-to-back words; it is cleared only when the block goes idle.
module cpfsk_modulator #(
  parameter int WORD_W          = 8,
  parameter int OUT_W           = 8,
  parameter int SAMPLES_PER_BIT = 32,
  parameter int PHASE_W         = 16,
  parameter int LUT_ADDR_W      = 6,
  parameter int PHASE_INC0      = 2048,
  parameter int PHASE_INC1      = 1024,
  parameter bit MSB_FIRST       = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sample_en,
  cpfsk_if.slave           s,
  output logic [OUT_W-1:0] dac_out,
  output logic             busy,
  output logic             word_done
);

  localparam int BIT_W  = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam int SAMP_W = $clog2(SAMPLES_PER_BIT);
  localparam int LUT_N  = 2 ** LUT_ADDR_W;
  localparam logic [OUT_W-1:0] MID = OUT_W'(2 ** (OUT_W - 1));
  localparam real PI = 3.14159265358979323846;

  typedef enum logic {IDLE, SEND} state_t;

  state_t              state, state_next;
  logic [PHASE_W-1:0]  phase;
  logic [WORD_W-1:0]   shreg;
  logic [BIT_W-1:0]    bit_idx;
  logic [SAMP_W-1:0]   samp_cnt;
  logic                cur_bit;
  logic                last_samp;
  logic [PHASE_W-1:0]  phase_inc;
  logic [OUT_W-1:0]    rom [LUT_N];

  // Rounded offset sine, clipped so the positive peak fits in OUT_W bits.
  function automatic logic [OUT_W-1:0] lut_val(input int k);
    real m;
    real v;
    int  r;
    m = 2.0 ** (OUT_W - 1);
    v = m + m * $sin(2.0 * PI * k / (2.0 ** LUT_ADDR_W));
    r = $rtoi(v + 0.5);
    if (r > 2 ** OUT_W - 1) r = 2 ** OUT_W - 1;
    if (r < 0) r = 0;
    return OUT_W'(r);
  endfunction

  // NOTE: the ROM is pure elaboration-time constants, so it has no reset and no write port.
  for (genvar k = 0; k < LUT_N; k++) begin : g_rom
    localparam logic [OUT_W-1:0] VAL = lut_val(k);
    assign rom[k] = VAL;
  end

  assign cur_bit   = MSB_FIRST ? shreg[WORD_W-1] : shreg[0];
  assign phase_inc = cur_bit ? PHASE_W'(PHASE_INC1) : PHASE_W'(PHASE_INC0);
  assign last_samp = (samp_cnt == SAMP_W'(SAMPLES_PER_BIT - 1));

  // NOTE: every output of this block gets a default first so no path infers a latch.
  always_comb begin
    state_next = state;
    busy       = (state == SEND);
    word_done  = 1'b0;
    s.s_ready  = 1'b0;
    case (state)
      IDLE: begin
        s.s_ready = 1'b1;
        if (s.s_valid) state_next = SEND;
      end
      SEND: begin
        word_done = sample_en && last_samp && (bit_idx == BIT_W'(WORD_W - 1));
        s.s_ready = word_done;
        if (word_done && !s.s_valid) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase    <= '0;
      shreg    <= '0;
      bit_idx  <= '0;
      samp_cnt <= '0;
      dac_out  <= MID;
    end else begin
      case (state)
        IDLE: begin
          dac_out <= MID;
          phase   <= '0;
          if (s.s_valid) begin
            shreg    <= s.s_data;
            bit_idx  <= '0;
            samp_cnt <= '0;
          end
        end
        SEND: begin
          if (sample_en) begin
            dac_out <= rom[phase[PHASE_W-1 -: LUT_ADDR_W]];
            if (word_done) begin
              bit_idx  <= '0;
              samp_cnt <= '0;
              // Back-to-back words keep the running phase; going idle clears it.
              if (s.s_valid) begin
                shreg <= s.s_data;
                phase <= phase + phase_inc;
              end else begin
                phase <= '0;
              end
            end else begin
              phase <= phase + phase_inc;
              if (last_samp) begin
                samp_cnt <= '0;
                bit_idx  <= bit_idx + 1'b1;
                shreg    <= MSB_FIRST ? (shreg << 1) : (shreg >> 1);
              end else begin
                samp_cnt <= samp_cnt + 1'b1;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cpfsk_modulator.sv
// Self-checking bench: a sample-index model of the modulator is compared on every negedge,
// and a few hand-computed sample values pin that model.
module tb_cpfsk_modulator;

  localparam int WORD_W     = 8;
  localparam int OUT_W      = 8;
  localparam int SPB        = 32;
  localparam int PHASE_W    = 16;
  localparam int LUT_ADDR_W = 6;
  localparam int INC0       = 2048;
  localparam int INC1       = 1024;
  localparam bit MSB_FIRST  = 1'b0;
  localparam int SPW        = WORD_W * SPB;
  localparam int MID        = 1 << (OUT_W - 1);

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             sample_en = 1'b0;
  logic [OUT_W-1:0] dac_out;
  logic             busy;
  logic             word_done;

  cpfsk_if #(.WORD_W(WORD_W)) bus ();

  cpfsk_modulator #(
    .WORD_W(WORD_W), .OUT_W(OUT_W), .SAMPLES_PER_BIT(SPB), .PHASE_W(PHASE_W),
    .LUT_ADDR_W(LUT_ADDR_W), .PHASE_INC0(INC0), .PHASE_INC1(INC1), .MSB_FIRST(MSB_FIRST)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .sample_en (sample_en),
    .s         (bus),
    .dac_out   (dac_out),
    .busy      (busy),
    .word_done (word_done)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int duty   = 0;
  int ready_in_send = 0;
  int cap[$];
  int done_cyc[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic int lut(input int k);
    real v;
    int  r;
    v = MID + MID * $sin(2.0 * 3.14159265358979323846 * k / (2.0 ** LUT_ADDR_W));
    r = $rtoi(v + 0.5);
    if (r > (1 << OUT_W) - 1) r = (1 << OUT_W) - 1;
    if (r < 0) r = 0;
    return r;
  endfunction

  function automatic int bit_at(input logic [WORD_W-1:0] w, input int b);
    return MSB_FIRST ? int'(w[WORD_W-1-b]) : int'(w[b]);
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Strobe generator: duty 0 = off, 1 = every clock, N = one clock in N.
  initial forever begin
    @(posedge clk);
    #1;
    sample_en = (duty == 0) ? 1'b0 : ((duty == 1) ? 1'b1 : ((cyc % duty) == 0));
  end

  // Model: word position is a sample index 0..SPW-1; phase is an integer modulo 2**PHASE_W.
  int               m_busy, m_n, m_phase, m_dac, m_strobe, exp_wd;
  logic [WORD_W-1:0] m_word;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 0; m_n = 0; m_phase = 0; m_dac = MID; m_strobe = 0; m_word = '0;
    end else begin
      m_strobe = 0;
      if (m_busy == 0) begin
        m_dac   = MID;
        m_phase = 0;
        if (bus.s_valid) begin
          m_word = bus.s_data; m_n = 0; m_busy = 1;
        end
      end else if (sample_en) begin
        m_strobe = 1;
        m_dac    = lut(m_phase >> (PHASE_W - LUT_ADDR_W));
        m_phase  = (m_phase + (bit_at(m_word, m_n / SPB) ? INC1 : INC0)) % (1 << PHASE_W);
        if (m_n == SPW - 1) begin
          if (bus.s_valid) begin
            m_word = bus.s_data; m_n = 0;
          end else begin
            m_busy = 0; m_phase = 0;
          end
        end else begin
          m_n++;
        end
      end
    end
  end

  always @(negedge clk) begin
    exp_wd = (m_busy != 0 && sample_en && m_n == SPW - 1) ? 1 : 0;
    check("dac_out", dac_out, m_dac);
    check("busy", busy, m_busy);
    check("s_ready", bus.s_ready, (m_busy == 0 || exp_wd != 0) ? 1 : 0);
    check("word_done", word_done, exp_wd);
    if (m_strobe != 0) cap.push_back(int'(dac_out));
    if (word_done) done_cyc.push_back(cyc);
    if (m_busy != 0 && bus.s_ready) ready_in_send++;
  end

  // Waits for a negedge with s_ready high, then lets the next posedge take the word.
  task automatic wait_ready(input string name, input int limit);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.s_ready && n < limit);
    check({name, "_ready_seen"}, bus.s_ready, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input string name, input logic [WORD_W-1:0] d);
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    wait_ready(name, 5000);
    bus.s_valid = 1'b0;
  endtask

  task automatic wait_done(input string name, input int limit);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!word_done && n < limit);
    check({name, "_done_seen"}, word_done, 1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    bus.s_valid = 1'b0;
    bus.s_data  = '0;

    // Reset state and idle hold.
    repeat (3) @(posedge clk);
    #1;
    check("rst_dac", dac_out, MID);
    check("rst_ready", bus.s_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done", word_done, 0);
    rst  = 1'b0;
    duty = 1;
    repeat (6) @(posedge clk);
    #1;
    check("idle_dac", dac_out, MID);

    // Word 0x00: one full sine per bit.
    cap.delete();
    send_word("w00", 8'h00);
    wait_done("w00", 2000);
    check("w00_len", cap.size(), SPW);
    check("w00_s0", cap[0], 128);
    check("w00_s1", cap[1], 153);
    check("w00_s2", cap[2], 177);
    check("w00_s3", cap[3], 199);
    check("w00_s8", cap[8], 255);
    check("w00_s16", cap[16], 128);
    check("w00_s24", cap[24], 0);
    check("w00_s255", cap[255], 103);
    check("w00_idle_dac", dac_out, MID);
    check("w00_idle_ready", bus.s_ready, 1);

    // Word 0x01: half sine for bit 0, bit 1 continues from pi.
    cap.delete();
    send_word("w01", 8'h01);
    wait_done("w01", 2000);
    check("w01_s0", cap[0], 128);
    check("w01_s16", cap[16], 255);
    check("w01_s32", cap[32], 128);
    check("w01_s33", cap[33], 103);
    check("w01_s34", cap[34], 79);

    // Back-to-back 0xA5 then 0x3C with s_valid held.
    done_cyc.delete();
    ready_in_send = 0;
    bus.s_valid = 1'b1;
    bus.s_data  = 8'hA5;
    wait_ready("b2b_a", 10);
    bus.s_data  = 8'h3C;
    wait_ready("b2b_b", 2000);
    bus.s_valid = 1'b0;
    check("b2b_ready_pulses", ready_in_send, 1);
    wait_done("b2b", 2000);
    check("b2b_done_count", done_cyc.size(), 2);
    if (done_cyc.size() == 2) check("b2b_spacing", done_cyc[1] - done_cyc[0], SPW);

    // Strobe 1-in-4, two 0xFF words back-to-back.
    duty = 4;
    cap.delete();
    done_cyc.delete();
    bus.s_valid = 1'b1;
    bus.s_data  = 8'hFF;
    wait_ready("d4_a", 10);
    wait_ready("d4_b", 5000);
    bus.s_valid = 1'b0;
    wait_done("d4", 5000);
    check("d4_done_count", done_cyc.size(), 2);
    if (done_cyc.size() == 2) check("d4_spacing", done_cyc[1] - done_cyc[0], 4 * SPW);
    check("d4_s0", cap[0], 128);
    check("d4_s16", cap[16], 255);

    // Reset in the middle of 0x5A.
    duty = 1;
    send_word("w5a", 8'h5A);
    repeat (99) @(posedge clk);
    done_cyc.delete();
    #1;
    rst = 1'b1;
    #1;
    check("mid_rst_dac", dac_out, MID);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", word_done, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("mid_rst_no_done", done_cyc.size(), 0);
    cap.delete();
    send_word("post_rst", 8'h00);
    wait_done("post_rst", 2000);
    check("post_rst_s0", cap[0], 128);
    check("post_rst_s1", cap[1], 153);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1);
  end

endmodule
